// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per op.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  assign fa_s = sh_a[0] ^ sh_b[0] ^ carry;
  assign fa_c = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Subtraction is a + ~b + 1: B is inverted on load and the carry seeded with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          result <= {fa_s, result[WIDTH-1:1]};
          carry  <= fa_c;
          // Final carry and MSB carry-in are captured here so they are valid while done is high.
          if (cnt == LAST) begin
            cout  <= fa_c;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= carry ^ fa_c;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: arithmetic reference model, per-cycle compare, directed and random ops.
// Checks ovf only when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  // Reference model state: cycles left until done, plus published outputs.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_result = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] t;
    t = s ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y});
    r = t[W-1:0];
    c = t[W];
    o = s ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
          : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_result = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done   = 1'b1;
        m_result = p_result;
        m_cout   = p_cout;
        m_ovf    = p_ovf;
      end
    end else if (start) begin
      ref_op(a, b, sub, p_result, p_cout, p_ovf);
      m_left = W;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", 32'(busy), 32'((m_left > 0) || m_done));
      checkOutput("done", 32'(done), 32'(m_done));
      if (done) done_count++;
      if (m_left == 0) begin
        checkOutput("result", 32'(result), 32'(m_result));
        checkOutput("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // noise bit k drives start (with junk operands) during cycle k of the operation.
  task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                               input logic [31:0] noise, output logic [W-1:0] r, output logic c,
                               output logic o, output int lat);
    a = xa;
    b = xb;
    sub = xs;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    for (int k = 1; k <= 4 * W; k++) begin
      @(negedge clk);
      start = noise[k % 32];
      a = 8'hAA;
      b = W'($urandom);
      if (done) begin
        lat = k;
        r = result;
        c = cout;
`ifdef SERIAL_ADDSUB_OVF_EN
        o = ovf;
`endif
        break;
      end
    end
    if (lat == 0) checkOutput("done_timeout", 32'(lat), 32'(W + 1));
    tick();
    start = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic [W-1:0] er, input logic ec);
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           lat;
    applyStimulus(xa, xb, xs, 32'h0, r, c, o, lat);
    checkOutput({name, "_result"}, 32'(r), 32'(er));
    checkOutput({name, "_cout"}, 32'(c), 32'(ec));
    checkOutput({name, "_latency"}, 32'(lat), 32'(W + 1));
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           lat;
    int           dc0;

    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_cout", 32'(cout), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    directed("add_3c_25", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    directed("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
    directed("sub_20_10", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1);

`ifdef SERIAL_ADDSUB_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0, 32'h0, r, c, o, lat);
    checkOutput("ovf_add_result", 32'(r), 32'h80);
    checkOutput("ovf_add_flag", 32'(o), 32'h1);
    applyStimulus(8'h80, 8'h01, 1'b1, 32'h0, r, c, o, lat);
    checkOutput("ovf_sub_result", 32'(r), 32'h7F);
    checkOutput("ovf_sub_flag", 32'(o), 32'h1);
    applyStimulus(8'hFF, 8'h01, 1'b0, 32'h0, r, c, o, lat);
    checkOutput("ovf_none_flag", 32'(o), 32'h0);
`endif

    // Start pulses in cycles 3 (RUN) and 9 (DONE) must be ignored.
    dc0 = done_count;
    applyStimulus(8'h01, 8'h02, 1'b0, (32'h1 << 3) | (32'h1 << 9), r, c, o, lat);
    checkOutput("ignore_start_result", 32'(r), 32'h03);
    repeat (12) tick();
    checkOutput("ignore_start_dones", 32'(done_count - dc0), 32'h1);

    // Asynchronous reset during the 4th RUN cycle.
    a = 8'h55;
    b = 8'h11;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_done", 32'(done), 32'h0);
    checkOutput("midrst_result", 32'(result), 32'h0);
    checkOutput("midrst_cout", 32'(cout), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    directed("after_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), $urandom, r, c, o, lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
